// File: rtl/psk_frame_ctrl.sv
// PSK frame controller: hunts for a sync word in a BPSK/QPSK hard-decision
// stream, reads a length byte, then streams the payload bytes out on an
// AXI-Stream style interface with a single-entry output register.
module psk_frame_ctrl #(
   parameter logic [15:0] SYNC_WORD    = 16'hEB90,
   parameter int unsigned HUNT_TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst_32M768,
   input  logic       clk_enable,
   input  logic       mode,
   input  logic       start,
   input  logic       abort,
   input  logic       sym_bpsk,
   input  logic [1:0] sym_qpsk,
   input  logic       sym_vld,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   output logic       m_tlast,
   input  logic       m_tready,
   output logic       busy,
   output logic       frame_done,
   output logic       timeout,
   output logic       overflow
);

   localparam int unsigned CW = $clog2(HUNT_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, HUNT, LEN, PAYLOAD, DONE} state_t;

   state_t          state, state_n;
   logic            mode_q, mode_n;
   logic [15:0]     sync_q, sync_n;
   logic [7:0]      byte_q, byte_n;
   logic [2:0]      bcnt_q, bcnt_n;
   logic [CW-1:0]   scnt_q, scnt_n;
   logic [7:0]      rem_q, rem_n;
   logic [7:0]      tdata_n;
   logic            tvalid_n, tlast_n, ovf_n, fd_n, to_n, busy_n;

   logic            in_frame;
   logic            acc;
   logic [15:0]     sync_sh;
   logic [7:0]      byte_sh;
   logic [3:0]      bsum;
   logic            byte_done;
   logic            slot_free;
   logic [CW-1:0]   scnt_inc;

   // Symbol-path helpers: shifted registers, bit-counter carry, output slot status
   assign in_frame  = (state == HUNT) || (state == LEN) || (state == PAYLOAD);
   assign acc       = clk_enable && sym_vld && in_frame && !abort;
   assign sync_sh   = mode_q ? {sync_q[13:0], sym_qpsk} : {sync_q[14:0], sym_bpsk};
   assign byte_sh   = mode_q ? {byte_q[5:0], sym_qpsk}  : {byte_q[6:0], sym_bpsk};
   assign bsum      = {1'b0, bcnt_q} + (mode_q ? 4'd2 : 4'd1);
   assign byte_done = acc && bsum[3];
   assign slot_free = !m_tvalid || m_tready;
   assign scnt_inc  = scnt_q + CW'(1);

   // Next-state, datapath and output computation
   always_comb begin
      state_n  = state;
      mode_n   = mode_q;
      sync_n   = sync_q;
      byte_n   = byte_q;
      bcnt_n   = bcnt_q;
      scnt_n   = scnt_q;
      rem_n    = rem_q;
      tdata_n  = m_tdata;
      tvalid_n = m_tvalid;
      tlast_n  = m_tlast;
      ovf_n    = overflow;
      to_n     = 1'b0;

      // Output handshake runs every clock, independent of clk_enable and abort
      if (m_tvalid && m_tready) begin
         tvalid_n = 1'b0;
         tdata_n  = '0;
         tlast_n  = 1'b0;
      end

      if (acc) begin
         sync_n = sync_sh;
         byte_n = byte_sh;
         bcnt_n = bsum[2:0];
      end

      if (abort) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_n = HUNT;
                  mode_n  = mode;
                  sync_n  = '0;
                  byte_n  = '0;
                  bcnt_n  = '0;
                  scnt_n  = '0;
                  ovf_n   = 1'b0;
               end
            end
            HUNT: begin
               if (acc) begin
                  scnt_n = scnt_inc;
                  // A sync match on the final allowed symbol wins over the timeout
                  if (sync_sh == SYNC_WORD) begin
                     state_n = LEN;
                     bcnt_n  = '0;
                  end else if (scnt_inc == CW'(HUNT_TIMEOUT)) begin
                     state_n = IDLE;
                     to_n    = 1'b1;
                  end
               end
            end
            LEN: begin
               if (byte_done) begin
                  if (byte_sh == 8'd0) begin
                     state_n = DONE;
                  end else begin
                     state_n = PAYLOAD;
                     rem_n   = byte_sh;
                  end
               end
            end
            PAYLOAD: begin
               if (byte_done) begin
                  rem_n = rem_q - 8'd1;
                  // A byte arriving while the slot is still occupied is dropped;
                  // the pending byte (including its tlast) is left untouched
                  if (slot_free) begin
                     tdata_n  = byte_sh;
                     tvalid_n = 1'b1;
                     tlast_n  = (rem_q == 8'd1);
                  end else begin
                     ovf_n = 1'b1;
                  end
                  if (rem_q == 8'd1) state_n = DONE;
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end

      fd_n   = (state_n == DONE);
      busy_n = (state_n != IDLE);
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst_32M768) begin
      if (rst_32M768) begin
         state      <= IDLE;
         mode_q     <= 1'b0;
         sync_q     <= '0;
         byte_q     <= '0;
         bcnt_q     <= '0;
         scnt_q     <= '0;
         rem_q      <= '0;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_n;
         mode_q     <= mode_n;
         sync_q     <= sync_n;
         byte_q     <= byte_n;
         bcnt_q     <= bcnt_n;
         scnt_q     <= scnt_n;
         rem_q      <= rem_n;
         m_tdata    <= tdata_n;
         m_tvalid   <= tvalid_n;
         m_tlast    <= tlast_n;
         busy       <= busy_n;
         frame_done <= fd_n;
         timeout    <= to_n;
         overflow   <= ovf_n;
      end
   end

endmodule
